mul_job_sequencer: RTL

//  Upstream feeder/collector for the radix-2 Booth multiplier. Buffers operand pairs from a

---
 rtl/mul_job_sequencer_pkg.sv | 20 ++
 rtl/mul_operand_fifo.sv | 58 +++++
 rtl/mul_job_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mul_job_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_job_sequencer_pkg
// Brief    : Shared state encoding and default sizing for the job sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mul_job_sequencer_pkg;

    localparam int unsigned c_DEF_WIDTH      = 64;
    localparam int unsigned c_DEF_FIFO_DEPTH = 4;
    localparam int unsigned c_DEF_TIMEOUT    = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mul_operand_fifo
// Brief    : Synchronous operand-pair FIFO; full pushes and empty pops are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module mul_operand_fifo
    import mul_job_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * c_DEF_WIDTH,
    parameter int unsigned DEPTH  = c_DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned   c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full    = (r_count == c_DEPTH_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/mul_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_job_sequencer
// Brief    : Feeds queued operand pairs to a multiplier one job at a time and
//            hands products downstream, with a watchdog against a hung core.
// Revision : 1.0 - initial release
// ============================================================================
module mul_job_sequencer
    import mul_job_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = c_DEF_WIDTH,
    parameter int unsigned FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    parameter int unsigned TIMEOUT    = c_DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_multiplier,
    input  logic [WIDTH-1:0]   in_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplier,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic               mul_op_start,
    output logic               mul_op_clear,
    input  logic               mul_op_done,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               busy,
    output logic               err_timeout
);

    localparam int unsigned         c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0]   c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic               w_pop;
    logic               w_capture;
    logic               w_timeout;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [2*WIDTH-1:0] w_head;
    logic [c_WD_W-1:0]  r_wdog;
    logic [WIDTH-1:0]   r_mul_multiplier;
    logic [WIDTH-1:0]   r_mul_multiplicand;
    logic               r_op_start;
    logic               r_op_clear;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out_result;
    logic               r_err_timeout;

    mul_operand_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (in_valid && in_ready),
        .i_pop     (w_pop),
        .i_wr_data ({in_multiplier, in_multiplicand}),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Held low during reset so the producer never sees a ready it cannot use.
    assign in_ready         = reset_n && !w_fifo_full;
    assign busy             = (r_state != ST_IDLE) || !w_fifo_empty;
    assign mul_multiplier   = r_mul_multiplier;
    assign mul_multiplicand = r_mul_multiplicand;
    assign mul_op_start     = r_op_start;
    assign mul_op_clear     = r_op_clear;
    assign out_valid        = r_out_valid;
    assign out_result       = r_out_result;
    assign err_timeout      = r_err_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A finished job waits here while the output slot is still occupied.
                if (mul_op_done) begin
                    if (!r_out_valid || out_ready) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_CLEAR;
                    end
                end else if (r_wdog == c_WD_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_start         <= 1'b0;
            r_op_clear         <= 1'b0;
            r_err_timeout      <= 1'b0;
            r_wdog             <= '0;
            r_mul_multiplier   <= '0;
            r_mul_multiplicand <= '0;
            r_out_valid        <= 1'b0;
            r_out_result       <= '0;
        end else begin
            r_op_start    <= (w_state_nxt == ST_RUN);
            r_op_clear    <= (w_state_nxt == ST_CLEAR);
            r_err_timeout <= w_timeout;
            if (w_pop) begin
                r_mul_multiplier   <= w_head[2*WIDTH-1:WIDTH];
                r_mul_multiplicand <= w_head[WIDTH-1:0];
                r_wdog             <= '0;
            end else if (r_state == ST_RUN && !mul_op_done) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_capture) begin
                r_out_result <= mul_result;
                r_out_valid  <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
